// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and width helpers for slave-side endpoints.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  // Number of byte lanes on a data bus of the given width.
  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  // Number of low address bits that select a byte inside one bus word.
  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite bundle (AW, W, B, AR, R) between one master and one slave.
// Latency: none (wiring only).
// Backpressure: carried by the per-channel VALID/READY pairs.
interface axi_lite_regfile_if
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  localparam int STRB_W = strb_width(DATA_WIDTH);

  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWVALID;
  logic [2:0]            AWPROT;
  logic                  AWREADY;

  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_W-1:0]     WSTRB;
  logic                  WVALID;
  logic                  WREADY;

  resp_t                 BRESP;
  logic                  BVALID;
  logic                  BREADY;

  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;

  logic [DATA_WIDTH-1:0] RDATA;
  resp_t                 RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWVALID, AWPROT, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, AWPROT, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file with byte strobes, RO status slots and SLVERR on decode/permission errors.
// Latency: write commits one edge after both AW and W are held; read data one edge after AR handshake.
// Backpressure: AW/W each buffer one beat; commit stalls while BVALID waits for BREADY; AR stalls while R is stalled.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  axi_lite_regfile_if.slave              s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_i,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int STRB_W   = strb_width(DATA_WIDTH);
  localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);

  // Write-side hold registers and B channel state
  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  resp_t                 bresp_q, bresp_d;
  logic [NUM_REGS-1:0]   wr_pulse_q;

  // Read channel state
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  resp_t                 rresp_q, rresp_d;

  logic                  aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok, arready;
  logic [ADDR_WIDTH-1:0] widx, ridx;
  logic [NUM_REGS-1:0]   wr_hit, rd_hit, wr_sel;
  logic [DATA_WIDTH-1:0] rd_slot [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_mux;

  assign widx    = awaddr_q >> ADDR_LSB;
  assign ridx    = s_axi.ARADDR >> ADDR_LSB;
  assign arready = !rvalid_q || s_axi.RREADY;

  assign aw_hs  = s_axi.AWVALID && !aw_held_q;
  assign w_hs   = s_axi.WVALID && !w_held_q;
  assign ar_hs  = s_axi.ARVALID && arready;
  assign commit = aw_held_q && w_held_q && !bvalid_q;

  // A write is accepted only when it lands on a writable in-range slot.
  assign wr_ok  = |(wr_hit & ~RO_MASK);
  assign rd_ok  = |rd_hit;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign wr_hit[i] = (widx == ADDR_WIDTH'(i));
    assign rd_hit[i] = (ridx == ADDR_WIDTH'(i));
    assign wr_sel[i] = commit && wr_hit[i] && !RO_MASK[i];

    if (RO_MASK[i]) begin : g_ro
      assign rd_slot[i] = hw_i[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] reg_q, reg_d;

      // Merge strobed bytes of the held write data into this register.
      always_comb begin
        reg_d = reg_q;
        if (wr_sel[i]) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wstrb_q[b]) reg_d[8*b +: 8] = wdata_q[8*b +: 8];
          end
        end
      end

      // Register storage with reset to the configured value.
      always_ff @(posedge ACLK) begin
        if (ARESET) reg_q <= RESET_VAL;
        else        reg_q <= reg_d;
      end

      assign rd_slot[i] = reg_q;
    end

    assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = rd_slot[i];
  end

  // Read mux: one-hot select over all slots, zero when out of range.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_hit[i]) rd_mux = rd_mux | rd_slot[i];
    end
  end

  // Next-state for hold registers, B and R channels.
  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok ? OKAY : SLVERR;
    end else if (s_axi.BREADY) begin
      bvalid_d  = 1'b0;
    end

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axi.AWADDR;
    end
    if (w_hs) begin
      w_held_d  = 1'b1;
      wdata_d   = s_axi.WDATA;
      wstrb_d   = s_axi.WSTRB;
    end

    // Read data is captured only at AR handshake, so it holds while R stalls.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
      rresp_d  = rd_ok ? OKAY : SLVERR;
    end else if (s_axi.RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // Control and channel registers; reset drops any in-flight transaction.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held_q  <= 1'b0;
      awaddr_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
      wr_pulse_q <= '0;
    end else begin
      aw_held_q  <= aw_held_d;
      awaddr_q   <= awaddr_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_sel;
    end
  end

  assign s_axi.AWREADY = !aw_held_q;
  assign s_axi.WREADY  = !w_held_q;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.ARREADY = arready;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = rresp_q;
  assign wr_pulse_o    = wr_pulse_q;

  // AWPROT is ignored and hw_i slots of RW registers are not consumed.
  logic unused_bits;
  assign unused_bits = ^{s_axi.AWPROT, hw_i, awaddr_q, s_axi.ARADDR};

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Randomized and directed check of axi_lite_regfile against a word-level reference model.
module tb_axi_lite_regfile;
  import axi_lite_pkg::*;

  localparam int         NR = 4;
  localparam logic [3:0] RO = 4'b1000;

  logic ACLK = 1'b0;
  logic ARESET;
  logic [NR*32-1:0] regs_o;
  logic [NR*32-1:0] hw;
  logic [NR-1:0]    wr_pulse_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mdl [NR];

  always #5 ACLK = ~ACLK;

  axi_lite_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  axi_lite_regfile #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VAL(32'h0)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .s_axi     (bus),
    .regs_o    (regs_o),
    .hw_i      (hw),
    .wr_pulse_o(wr_pulse_o)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: word-indexed array, RO slot shadows hw, anything beyond NR is a decode error.
  function automatic int idx_of(input logic [31:0] a);
    return int'(a / 4);
  endfunction

  function automatic logic [1:0] exp_wresp(input logic [31:0] a);
    int i = idx_of(a);
    if (i >= NR) return 2'b10;
    if (RO[i]) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [31:0] a);
    return (idx_of(a) >= NR) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    int i = idx_of(a);
    if (i >= NR) return 32'h0;
    if (RO[i]) return hw[i*32 +: 32];
    return mdl[i];
  endfunction

  function automatic logic [3:0] exp_pulse(input logic [31:0] a);
    if (exp_wresp(a) != 2'b00) return 4'b0000;
    return 4'(1 << idx_of(a));
  endfunction

  function automatic logic [127:0] exp_regs();
    logic [127:0] r;
    for (int i = 0; i < NR; i++) r[i*32 +: 32] = RO[i] ? hw[i*32 +: 32] : mdl[i];
    return r;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    if (exp_wresp(a) == 2'b00) begin
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      mdl[idx_of(a)] = (mdl[idx_of(a)] & ~mask) | (d & mask);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mdl[i] = 32'h0;
  endtask

  // AW and W presented together, BREADY high; checks B timing, response, pulse and register image.
  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge ACLK);
    bus.AWADDR = a; bus.AWVALID = 1'b1;
    bus.WDATA = d; bus.WSTRB = s; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
    n = 0;
    while (!(bus.AWREADY && bus.WREADY) && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    chk("wr_ready_wait", 1'(n >= 20), 1'b0);
    @(negedge ACLK);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    chk("b_not_at_e0", bus.BVALID, 1'b0);
    model_write(a, d, s);
    @(negedge ACLK);
    chk("b_valid_e1", bus.BVALID, 1'b1);
    chk("b_resp", bus.BRESP, exp_wresp(a));
    chk("wr_pulse", wr_pulse_o, exp_pulse(a));
    chk("regs_after_wr", regs_o, exp_regs());
    @(negedge ACLK);
    chk("pulse_one_cycle", wr_pulse_o, 4'b0000);
    chk("b_cleared", bus.BVALID, 1'b0);
  endtask

  task automatic read_txn(input logic [31:0] a);
    int n;
    @(negedge ACLK);
    bus.ARADDR = a; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
    n = 0;
    while (!bus.ARREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    chk("ar_ready_wait", 1'(n >= 20), 1'b0);
    @(negedge ACLK);
    bus.ARVALID = 1'b0;
    chk("r_valid_lat1", bus.RVALID, 1'b1);
    chk("r_data", bus.RDATA, exp_rdata(a));
    chk("r_resp", bus.RRESP, exp_rresp(a));
    @(negedge ACLK);
    chk("r_cleared", bus.RVALID, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not end, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] old;
    logic [31:0] a;
    ARESET = 1'b1;
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.AWPROT = 3'b000;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    hw = {32'h0000_1234, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF};
    model_reset();
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;

    // Reset state
    chk("rst_awready", bus.AWREADY, 1'b1);
    chk("rst_wready", bus.WREADY, 1'b1);
    chk("rst_arready", bus.ARREADY, 1'b1);
    chk("rst_bvalid", bus.BVALID, 1'b0);
    chk("rst_rvalid", bus.RVALID, 1'b0);
    chk("rst_bresp", bus.BRESP, 2'b00);
    chk("rst_rresp", bus.RRESP, 2'b00);
    chk("rst_rdata", bus.RDATA, 32'h0);
    chk("rst_pulse", wr_pulse_o, 4'b0000);
    chk("rst_regs", regs_o, exp_regs());

    read_txn(32'h0);

    // Partial strobe write then readback
    write_txn(32'h4, 32'hDEADBEEF, 4'b0101);
    chk("strobe_merge", regs_o[63:32], 32'h00AD00EF);
    read_txn(32'h4);

    // Read and commit to the same register on the same edge: read sees old value
    @(negedge ACLK);
    bus.AWADDR = 32'h0; bus.AWVALID = 1'b1; bus.WDATA = 32'h1111_1111; bus.WSTRB = 4'hF;
    bus.WVALID = 1'b1; bus.BREADY = 1'b1;
    @(negedge ACLK);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    bus.ARADDR = 32'h0; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
    old = mdl[0];
    @(negedge ACLK);
    bus.ARVALID = 1'b0;
    model_write(32'h0, 32'h1111_1111, 4'hF);
    chk("same_edge_rdata_old", bus.RDATA, old);
    chk("same_edge_pulse", wr_pulse_o, 4'b0001);
    chk("same_edge_regs", regs_o, exp_regs());
    @(negedge ACLK);

    // W three cycles ahead of AW, B stalled, second AW/W buffered behind it
    bus.BREADY = 1'b0;
    bus.WDATA = 32'hCAFE_F00D; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    @(negedge ACLK);
    bus.WVALID = 1'b0;
    chk("w_held_ready_low", bus.WREADY, 1'b0);
    repeat (2) @(negedge ACLK);
    chk("w_alone_no_b", bus.BVALID, 1'b0);
    bus.AWADDR = 32'h8; bus.AWVALID = 1'b1;
    @(negedge ACLK);
    bus.AWVALID = 1'b0;
    chk("late_aw_b_e0", bus.BVALID, 1'b0);
    model_write(32'h8, 32'hCAFE_F00D, 4'hF);
    @(negedge ACLK);
    chk("late_aw_b_e1", bus.BVALID, 1'b1);
    chk("late_aw_resp", bus.BRESP, 2'b00);
    chk("late_aw_pulse", wr_pulse_o, 4'b0100);
    chk("late_aw_regs", regs_o, exp_regs());
    bus.AWADDR = 32'h0; bus.AWVALID = 1'b1; bus.WDATA = 32'h0BAD_C0DE; bus.WVALID = 1'b1;
    chk("aw2_ready", bus.AWREADY, 1'b1);
    @(negedge ACLK);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    chk("aw2_held", bus.AWREADY, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("b_stall_valid", bus.BVALID, 1'b1);
      chk("b_stall_resp", bus.BRESP, 2'b00);
      chk("b_stall_no_pulse", wr_pulse_o, 4'b0000);
      chk("b_stall_no_commit", regs_o, exp_regs());
      @(negedge ACLK);
    end
    bus.BREADY = 1'b1;
    @(negedge ACLK);
    chk("b1_done", bus.BVALID, 1'b0);
    model_write(32'h0, 32'h0BAD_C0DE, 4'hF);
    @(negedge ACLK);
    chk("b2_valid", bus.BVALID, 1'b1);
    chk("b2_pulse", wr_pulse_o, 4'b0001);
    chk("b2_regs", regs_o, exp_regs());
    @(negedge ACLK);
    chk("b2_done", bus.BVALID, 1'b0);

    // Permission and decode errors, RO status read
    write_txn(32'hC, 32'h5555_5555, 4'hF);
    write_txn(32'h10, 32'h6666_6666, 4'hF);
    read_txn(32'hC);
    read_txn(32'h10);

    // Back-to-back reads with RREADY high
    @(negedge ACLK);
    bus.RREADY = 1'b1; bus.ARVALID = 1'b1; bus.ARADDR = 32'h0;
    for (int k = 0; k < 4; k++) begin
      chk("b2b_arready", bus.ARREADY, 1'b1);
      @(negedge ACLK);
      chk("b2b_rvalid", bus.RVALID, 1'b1);
      chk("b2b_rdata", bus.RDATA, exp_rdata(32'(k * 4)));
      bus.ARADDR = 32'((k + 1) * 4);
    end
    bus.ARVALID = 1'b0;
    @(negedge ACLK);

    // R stall: ARREADY low, RDATA held, pending AR accepted on release
    bus.RREADY = 1'b0; bus.ARVALID = 1'b1; bus.ARADDR = 32'h4;
    @(negedge ACLK);
    bus.ARADDR = 32'h8;
    for (int k = 0; k < 3; k++) begin
      chk("stall_rvalid", bus.RVALID, 1'b1);
      chk("stall_arready", bus.ARREADY, 1'b0);
      chk("stall_rdata", bus.RDATA, exp_rdata(32'h4));
      @(negedge ACLK);
    end
    bus.RREADY = 1'b1;
    @(negedge ACLK);
    bus.ARVALID = 1'b0;
    chk("release_rvalid", bus.RVALID, 1'b1);
    chk("release_rdata", bus.RDATA, exp_rdata(32'h8));
    @(negedge ACLK);
    chk("release_cleared", bus.RVALID, 1'b0);

    // Randomized traffic against the model
    for (int it = 0; it < 80; it++) begin
      a = 32'($urandom_range(0, 5) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) hw = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 0) write_txn(a, $urandom, 4'($urandom_range(0, 15)));
      else                           read_txn(a);
    end

    // Reset between AW and W handshakes
    write_txn(32'h4, 32'h7777_7777, 4'hF);
    @(negedge ACLK);
    bus.AWADDR = 32'h4; bus.AWVALID = 1'b1; bus.BREADY = 1'b1;
    @(negedge ACLK);
    bus.AWVALID = 1'b0;
    chk("pre_rst_aw_held", bus.AWREADY, 1'b0);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    model_reset();
    chk("post_rst_awready", bus.AWREADY, 1'b1);
    chk("post_rst_wready", bus.WREADY, 1'b1);
    chk("post_rst_arready", bus.ARREADY, 1'b1);
    chk("post_rst_regs", regs_o, exp_regs());
    bus.WDATA = 32'h9999_9999; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    @(negedge ACLK);
    bus.WVALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_no_b", bus.BVALID, 1'b0);
      chk("post_rst_no_pulse", wr_pulse_o, 4'b0000);
      chk("post_rst_regs_kept", regs_o, exp_regs());
      @(negedge ACLK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
